// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial evaluator subsystem.
//
// Holds the data width, the feeder FSM state encoding, the field-index
// constants that order the four strokes, the registered tuple type and a
// small helper that picks one field out of a tuple. The evaluator top uses
// the same package, so both sides agree on the stroke order A, B, C, X.
package poly_pkg;

    localparam int unsigned DataWidth = 8;

    typedef logic [DataWidth-1:0] data_t;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StSetup     = 2'd1,
        StPress     = 2'd2,
        StWaitValid = 2'd3
    } feeder_state_e;

    typedef logic [1:0] field_idx_t;

    localparam field_idx_t FieldA = 2'd0;
    localparam field_idx_t FieldB = 2'd1;
    localparam field_idx_t FieldC = 2'd2;
    localparam field_idx_t FieldX = 2'd3;

    typedef struct packed {
        data_t a;
        data_t b;
        data_t c;
        data_t x;
    } tuple_t;

    function automatic data_t select_field(input tuple_t t, input field_idx_t idx);
        data_t f;
        case (idx)
            FieldA:  f = t.a;
            FieldB:  f = t.b;
            FieldC:  f = t.c;
            default: f = t.x;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/go_stroke.sv
// One Go stroke: GO_LOW cycles low followed by GO_HIGH cycles high.
//
// Ports
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset; forces go low immediately
//   start   begin a new stroke on this edge (also legal on the last high
//           cycle of the previous stroke, giving seamless back-to-back strokes)
//   go      registered, glitch-free stroke output
//   done    high on the last cycle of each phase; go tells which phase
//           (go=0: low phase ending, go=1: high phase ending)
module go_stroke #(
    parameter int unsigned GO_LOW  = 2,
    parameter int unsigned GO_HIGH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    output logic go,
    output logic done
);

    localparam logic [3:0] LowLoad  = 4'(GO_LOW - 1);
    localparam logic [3:0] HighLoad = 4'(GO_HIGH - 1);

    typedef enum logic [1:0] {
        PhIdle = 2'd0,
        PhLow  = 2'd1,
        PhHigh = 2'd2
    } phase_e;

    phase_e     phase_q;
    logic [3:0] cnt_q;
    logic       go_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q <= PhIdle;
            cnt_q   <= 4'd0;
            go_q    <= 1'b0;
        end else if (start) begin
            phase_q <= PhLow;
            cnt_q   <= LowLoad;
            go_q    <= 1'b0;
        end else begin
            case (phase_q)
                PhLow: begin
                    if (cnt_q == 4'd0) begin
                        phase_q <= PhHigh;
                        cnt_q   <= HighLoad;
                        go_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                PhHigh: begin
                    if (cnt_q == 4'd0) begin
                        phase_q <= PhIdle;
                        go_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    phase_q <= PhIdle;
                    go_q    <= 1'b0;
                end
            endcase
        end
    end

    assign go   = go_q;
    assign done = (phase_q != PhIdle) && (cnt_q == 4'd0);

endmodule

// File: rtl/poly_feeder.sv
// Feeds a coefficient tuple (A, B, C, X) into a stroke-driven evaluator of
// A*X*X + B*X + C and returns its 8-bit result.
//
// Each accepted tuple produces exactly four Go strokes presenting A, B, C and
// X on ev_data; the block then waits up to TIMEOUT cycles for ev_result_valid.
// All arithmetic happens in the evaluator; values pass through untouched.
//
// Ports
//   clk, resetn        clock and asynchronous active-low reset
//   in_valid/in_ready  tuple handshake; in_ready is high only when idle
//   in_a..in_x         tuple fields, registered on acceptance
//   ev_data, ev_go     evaluator DataIn and Go (both registered)
//   ev_result(_valid)  evaluator DataResult / ResultValid
//   out_valid          one-cycle pulse, out_result has just been loaded
//   out_result         last captured result, held between captures
//   out_err            one-cycle pulse, result did not arrive in time
//   busy               high whenever not idle
//
// An asynchronous reset drops ev_go at once; the evaluator must be reset in
// the same window because it does not resynchronise to a cut-short stroke.
module poly_feeder
    import poly_pkg::*;
#(
    parameter int unsigned GO_LOW  = 2,
    parameter int unsigned GO_HIGH = 2,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DataWidth-1:0] in_a,
    input  logic [DataWidth-1:0] in_b,
    input  logic [DataWidth-1:0] in_c,
    input  logic [DataWidth-1:0] in_x,
    output logic [DataWidth-1:0] ev_data,
    output logic                 ev_go,
    input  logic [DataWidth-1:0] ev_result,
    input  logic                 ev_result_valid,
    output logic                 out_valid,
    output logic [DataWidth-1:0] out_result,
    output logic                 out_err,
    output logic                 busy
);

    // Last wait-counter value before the timeout fires; the counter starts at
    // 0 on entry, so the error pulse appears TIMEOUT edges after entry.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    feeder_state_e state_q;
    field_idx_t    idx_q;
    tuple_t        tuple_q;
    data_t         ev_data_q;
    logic [7:0]    wait_q;
    data_t         out_result_q;
    logic          out_valid_q;
    logic          out_err_q;

    logic accept;
    logic stroke_start;
    logic stroke_done;
    logic stroke_go;

    assign accept = (state_q == StIdle) && in_valid;

    // A new stroke starts on acceptance and after every stroke except X.
    assign stroke_start = accept ||
                          ((state_q == StPress) && stroke_done && (idx_q != FieldX));

    go_stroke #(
        .GO_LOW  (GO_LOW),
        .GO_HIGH (GO_HIGH)
    ) u_go_stroke (
        .clk    (clk),
        .resetn (resetn),
        .start  (stroke_start),
        .go     (stroke_go),
        .done   (stroke_done)
    );

    // The FSM moves in lockstep with the stroke generator: SETUP covers its
    // low phase and PRESS its high phase, both ending on stroke_done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            idx_q        <= FieldA;
            tuple_q      <= '0;
            ev_data_q    <= '0;
            wait_q       <= 8'd0;
            out_result_q <= '0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        tuple_q   <= '{a: in_a, b: in_b, c: in_c, x: in_x};
                        idx_q     <= FieldA;
                        ev_data_q <= in_a;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    if (stroke_done) begin
                        state_q <= StPress;
                    end
                end
                StPress: begin
                    if (stroke_done) begin
                        if (idx_q == FieldX) begin
                            // ev_data keeps showing X while waiting.
                            wait_q  <= 8'd0;
                            state_q <= StWaitValid;
                        end else begin
                            idx_q     <= idx_q + 2'd1;
                            ev_data_q <= select_field(tuple_q, idx_q + 2'd1);
                            state_q   <= StSetup;
                        end
                    end
                end
                StWaitValid: begin
                    if (ev_result_valid) begin
                        out_result_q <= ev_result;
                        out_valid_q  <= 1'b1;
                        state_q      <= StIdle;
                    end else if (wait_q == TimeoutLast) begin
                        out_err_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign ev_data    = ev_data_q;
    assign ev_go      = stroke_go;
    assign out_result = out_result_q;
    assign out_valid  = out_valid_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_poly_feeder.sv
// Directed bench for poly_feeder with a behavioural stroke evaluator.
module tb_poly_feeder;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic [7:0] in_c = 8'd0;
    logic [7:0] in_x = 8'd0;
    logic [7:0] ev_data;
    logic       ev_go;
    logic [7:0] ev_result;
    logic       ev_result_valid;
    logic       out_valid;
    logic [7:0] out_result;
    logic       out_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    poly_feeder #(
        .GO_LOW  (2),
        .GO_HIGH (2),
        .TIMEOUT (32)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_a            (in_a),
        .in_b            (in_b),
        .in_c            (in_c),
        .in_x            (in_x),
        .ev_data         (ev_data),
        .ev_go           (ev_go),
        .ev_result       (ev_result),
        .ev_result_valid (ev_result_valid),
        .out_valid       (out_valid),
        .out_result      (out_result),
        .out_err         (out_err),
        .busy            (busy)
    );

    // Behavioural evaluator plus stroke monitor. Captures DataIn on each
    // rising Go, counts high/low run lengths, and raises ResultValid a few
    // cycles after the X stroke ends; the next stroke drops ResultValid.
    logic       eval_enable = 1'b1;
    logic       go_prev;
    int         stroke_total = 0;
    logic [7:0] stroke_data [0:255];
    int         hi_len [0:255];
    int         lo_len [0:255];
    int         hi_cnt;
    int         lo_cnt;
    logic [7:0] ea, eb, ec, ex;
    int         eval_k;
    logic       pending;
    int         lat;
    wire  [7:0] cur_idx  = stroke_total[7:0];
    wire  [7:0] last_idx = cur_idx - 8'd1;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            go_prev         <= 1'b0;
            eval_k          <= 0;
            pending         <= 1'b0;
            lat             <= 0;
            ev_result_valid <= 1'b0;
            ev_result       <= 8'd0;
            hi_cnt          <= 0;
            lo_cnt          <= 0;
        end else begin
            go_prev <= ev_go;
            if (!busy) lo_cnt <= 0;
            else if (!ev_go) lo_cnt <= go_prev ? 1 : lo_cnt + 1;
            if (ev_go && !go_prev) begin
                stroke_data[cur_idx] <= ev_data;
                lo_len[cur_idx]      <= lo_cnt;
                stroke_total         <= stroke_total + 1;
                hi_cnt               <= 1;
                ev_result_valid      <= 1'b0;
                case (eval_k)
                    0: ea <= ev_data;
                    1: eb <= ev_data;
                    2: ec <= ev_data;
                    default: begin
                        ex      <= ev_data;
                        pending <= 1'b1;
                    end
                endcase
                eval_k <= (eval_k + 1) % 4;
            end else if (ev_go) begin
                hi_cnt <= hi_cnt + 1;
            end
            if (!ev_go && go_prev) begin
                hi_len[last_idx] <= hi_cnt;
                if (pending) begin
                    pending <= 1'b0;
                    if (eval_enable) lat <= 3;
                end
            end
            if (lat > 0) begin
                if (lat == 1) begin
                    ev_result_valid <= 1'b1;
                    ev_result       <= ea * ex * ex + eb * ex + ec;
                end
                lat <= lat - 1;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] x);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_a = a; in_b = b; in_c = c; in_x = x;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(output logic v, output logic e);
        v = 1'b0;
        e = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid || out_err) begin
                v = out_valid;
                e = out_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (ev_go !== 1'b0)      begin errors++; $display("FAIL rst_go: got %b want 0", ev_go); end
        if (ev_data !== 8'd0)    begin errors++; $display("FAIL rst_data: got %0d want 0", ev_data); end
        if (out_result !== 8'd0) begin errors++; $display("FAIL rst_result: got %0d want 0", out_result); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        if (out_err !== 1'b0)    begin errors++; $display("FAIL rst_err: got %b want 0", out_err); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        logic       v, e;
        int         base;
        logic [7:0] exp_d [4];
        exp_d = '{8'd2, 8'd3, 8'd4, 8'd5};
        base = stroke_total;
        send(8'd2, 8'd3, 8'd4, 8'd5);
        wait_done(v, e);
        checks += 4;
        if (v !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", v); end
        if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", e); end
        if (out_result !== 8'd69) begin errors++; $display("FAIL basic_result: got %0d want 69", out_result); end
        if (stroke_total - base !== 4) begin errors++; $display("FAIL basic_strokes: got %0d want 4", stroke_total - base); end
        for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (stroke_data[8'(base + i)] !== exp_d[i]) begin
                errors++; $display("FAIL basic_data%0d: got %0d want %0d", i, stroke_data[8'(base + i)], exp_d[i]);
            end
            if (hi_len[8'(base + i)] !== 2) begin
                errors++; $display("FAIL basic_high%0d: got %0d want 2", i, hi_len[8'(base + i)]);
            end
            if (lo_len[8'(base + i)] !== 2) begin
                errors++; $display("FAIL basic_low%0d: got %0d want 2", i, lo_len[8'(base + i)]);
            end
        end
        @(negedge clk);
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b want 0", out_valid); end
        if (out_result !== 8'd69) begin errors++; $display("FAIL basic_hold: got %0d want 69", out_result); end
        if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy); end
        if (ev_data !== 8'd5) begin errors++; $display("FAIL basic_idle_data: got %0d want 5", ev_data); end
    endtask

    task automatic test_second;
        logic       v, e;
        int         base;
        logic [7:0] exp_d [4];
        exp_d = '{8'd1, 8'd1, 8'd1, 8'd3};
        base = stroke_total;
        send(8'd1, 8'd1, 8'd1, 8'd3);
        wait_done(v, e);
        checks += 3;
        if (v !== 1'b1) begin errors++; $display("FAIL second_valid: got %b want 1", v); end
        if (out_result !== 8'd13) begin errors++; $display("FAIL second_result: got %0d want 13", out_result); end
        if (stroke_total - base !== 4) begin errors++; $display("FAIL second_strokes: got %0d want 4", stroke_total - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (stroke_data[8'(base + i)] !== exp_d[i]) begin
                errors++; $display("FAIL second_data%0d: got %0d want %0d", i, stroke_data[8'(base + i)], exp_d[i]);
            end
        end
    endtask

    task automatic test_overflow;
        logic v, e;
        send(8'd10, 8'd0, 8'd0, 8'd10);
        wait_done(v, e);
        checks += 3;
        if (v !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", v); end
        if (e !== 1'b0) begin errors++; $display("FAIL ovf_err: got %b want 0", e); end
        if (out_result !== 8'd232) begin errors++; $display("FAIL ovf_result: got %0d want 232", out_result); end
    endtask

    task automatic test_timeout;
        int   base, n, k;
        logic saw_valid;
        eval_enable = 1'b0;
        base = stroke_total;
        send(8'd7, 8'd7, 8'd7, 8'd7);
        n = 0;
        @(negedge clk);
        while (!(stroke_total == base + 4 && !ev_go) && n < 300) begin
            @(negedge clk);
            n++;
        end
        k = 0;
        saw_valid = 1'b0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (out_valid) saw_valid = 1'b1;
            if (out_err) break;
        end
        checks += 4;
        if (k !== 32) begin errors++; $display("FAIL tmo_cycles: got %0d want 32", k); end
        if (out_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", out_err); end
        if (saw_valid !== 1'b0) begin errors++; $display("FAIL tmo_novalid: got %b want 0", saw_valid); end
        if (out_result !== 8'd232) begin errors++; $display("FAIL tmo_result: got %0d want 232", out_result); end
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready: got %b want 1", in_ready); end
        if (out_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b want 0", out_err); end
        eval_enable = 1'b1;
    endtask

    task automatic test_hold_valid;
        int         base, base2, n;
        logic       v, e;
        logic [7:0] exp_d [4];
        exp_d = '{8'd1, 8'd2, 8'd3, 8'd4};
        base = stroke_total;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_a = 8'd1; in_b = 8'd2; in_c = 8'd3; in_x = 8'd4;
        @(posedge clk);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid || out_err) break;
            in_a = in_a + 8'd7;
        end
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b want 1", out_valid); end
        if (out_result !== 8'd27) begin errors++; $display("FAIL hold_result: got %0d want 27", out_result); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (stroke_data[8'(base + i)] !== exp_d[i]) begin
                errors++; $display("FAIL hold_data%0d: got %0d want %0d", i, stroke_data[8'(base + i)], exp_d[i]);
            end
        end
        base2 = stroke_total;
        in_a = 8'd2; in_b = 8'd0; in_c = 8'd1; in_x = 8'd3;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", busy); end
        in_valid = 1'b0;
        wait_done(v, e);
        checks += 3;
        if (v !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", v); end
        if (out_result !== 8'd19) begin errors++; $display("FAIL b2b_result: got %0d want 19", out_result); end
        if (stroke_data[8'(base2)] !== 8'd2) begin
            errors++; $display("FAIL b2b_first: got %0d want 2", stroke_data[8'(base2)]);
        end
    endtask

    task automatic test_reset_mid;
        int   base, n;
        logic v, e;
        base = stroke_total;
        send(8'd1, 8'd2, 8'd3, 8'd4);
        n = 0;
        @(negedge clk);
        while (stroke_total != base + 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ev_go !== 1'b1) begin errors++; $display("FAIL mid_pressing: got %b want 1", ev_go); end
        #2 resetn = 1'b0;
        #1;
        checks += 7;
        if (ev_go !== 1'b0)      begin errors++; $display("FAIL mid_go: got %b want 0", ev_go); end
        if (ev_data !== 8'd0)    begin errors++; $display("FAIL mid_data: got %0d want 0", ev_data); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (in_ready !== 1'b1)   begin errors++; $display("FAIL mid_ready: got %b want 1", in_ready); end
        if (out_result !== 8'd0) begin errors++; $display("FAIL mid_result: got %0d want 0", out_result); end
        if (out_valid !== 1'b0)  begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        if (out_err !== 1'b0)    begin errors++; $display("FAIL mid_err: got %b want 0", out_err); end
        @(negedge clk);
        resetn = 1'b1;
        base = stroke_total;
        send(8'd3, 8'd2, 8'd1, 8'd2);
        wait_done(v, e);
        checks += 3;
        if (v !== 1'b1) begin errors++; $display("FAIL fresh_valid: got %b want 1", v); end
        if (out_result !== 8'd17) begin errors++; $display("FAIL fresh_result: got %0d want 17", out_result); end
        if (stroke_total - base !== 4) begin errors++; $display("FAIL fresh_strokes: got %0d want 4", stroke_total - base); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second();
        test_overflow();
        test_timeout();
        test_hold_valid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/poly_feeder.md
POLY_FEEDER -- requirements
Module: poly_feeder

Interface
REQ-001 The block SHALL have parameter GO_LOW, default 2, meaning cycles ev_go is held low with data stable before each stroke (range 1..15).
REQ-002 The block SHALL have parameter GO_HIGH, default 2, meaning cycles ev_go is held high per stroke (range 1..15).
REQ-003 The block SHALL have parameter TIMEOUT, default 32, meaning maximum cycles waited for ev_result_valid (range 8..255).
REQ-004 Clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 Resetn  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  a coefficient tuple is offered.
REQ-007 in_ready  output  1  block accepts a tuple this cycle.
REQ-008 in_a, in_b, in_c, in_x  input  8 each  coefficients A, B, C and operand X of A*X*X+B*X+C.
REQ-009 ev_data  output  8  value presented to the evaluator's DataIn.
REQ-010 ev_go  output  1  stroke signal to the evaluator's Go.
REQ-011 ev_result  input  8  evaluator's DataResult.
REQ-012 ev_result_valid  input  1  evaluator's ResultValid.
REQ-013 out_valid  output  1  one-cycle pulse: out_result is new.
REQ-014 out_result  output  8  last captured result, held until the next capture.
REQ-015 out_err  output  1  one-cycle pulse: result timeout.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL accept a tuple on a rising edge where in_valid and in_ready are both high, registering all four fields; in_ready SHALL be high only in IDLE.
REQ-018 The FSM SHALL have states IDLE, SETUP, PRESS, WAIT_VALID, plus a 2-bit field index (0=A, 1=B, 2=C, 3=X).
REQ-019 On acceptance: IDLE->SETUP with index 0.
REQ-020 SETUP SHALL last exactly GO_LOW cycles with ev_go=0, then go to PRESS.
REQ-021 PRESS SHALL last exactly GO_HIGH cycles with ev_go=1; at its end, index<3 -> SETUP with index+1, index=3 -> WAIT_VALID.
REQ-022 ev_data SHALL equal the registered field selected by the index throughout SETUP and PRESS, SHALL hold X during WAIT_VALID, and SHALL keep its last value in IDLE.
REQ-023 ev_go SHALL be registered (glitch-free) and SHALL be 0 in IDLE and WAIT_VALID.
REQ-024 Each tuple SHALL produce exactly four strokes (A, B, C, X); the A stroke of a later tuple also acknowledges the evaluator's previous result.
REQ-025 In WAIT_VALID, on the first cycle ev_result_valid=1, the block SHALL load ev_result into out_result, pulse out_valid for one cycle, and return to IDLE.
REQ-026 A wait counter SHALL clear on entry to WAIT_VALID; if it reaches TIMEOUT without ev_result_valid, the block SHALL pulse out_err for one cycle, leave out_result unchanged, and return to IDLE.
REQ-027 in_valid while busy SHALL be ignored, with no effect on the registered tuple.
REQ-028 ev_result_valid outside WAIT_VALID SHALL be ignored.
REQ-029 Arithmetic SHALL be performed only by the evaluator; the feeder passes all values through unmodified as 8 bits.
REQ-030 Back-to-back operation: a tuple offered in the cycle the block returns to IDLE SHALL be accepted on the next edge.

Reset
REQ-031 Resetn low SHALL immediately force IDLE, index 0, all counters 0, ev_go=0, ev_data=0, out_result=0, out_valid=0, out_err=0, busy=0, in_ready=1 after release.
REQ-032 Reset mid-stroke SHALL drop ev_go to 0 asynchronously; the system SHALL assert the evaluator's reset in the same window, since the evaluator does not resynchronise on its own.

Structure
REQ-033 State encodings, the field-index constants and data width 8 SHALL live in shared package poly_pkg, also used by the evaluator top.
REQ-034 The GO_LOW/GO_HIGH stroke timing SHALL be one sub-module, go_stroke (start in, go and done out); the FSM, tuple register, wait counter and result register SHALL stay in poly_feeder.

Verification
REQ-035 Defaults, connected to the evaluator, tuple A=2 B=3 C=4 X=5 -> ev_go high for 2 cycles on four strokes showing data 2,3,4,5; out_valid pulse with out_result=0x45 (69).
REQ-036 Second tuple A=1 B=1 C=1 X=3 after the first -> exactly four strokes; ev_result_valid falls during the A stroke; out_result=0x0D (13).
REQ-037 Overflow tuple A=10 B=0 C=0 X=10 -> out_result=0xE8 (232), with no error.
REQ-038 ev_result_valid tied to 0, TIMEOUT=32 -> out_err pulses exactly 32 cycles after WAIT_VALID entry; out_result unchanged; in_ready back to 1.
REQ-039 in_valid held high throughout an operation with changing in_a -> only the first tuple used; the next is accepted one edge after IDLE.
REQ-040 Resetn pulsed low mid-PRESS of the C stroke -> ev_go=0 at once; all outputs take their reset values; a fresh tuple then evaluates correctly.
